cov_stall_monitor: RTL

COV_STALL_MONITOR -- requirements
Module: cov_stall_monitor

---
 rtl/cov_mon_pkg.sv | 19 +
 rtl/cov_stall_chan.sv | 66 ++++++
 rtl/cov_stall_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cov_mon_pkg.sv
// Shared types for the coverage stall monitor: FSM states and
// positions of the cause bits reported on irq_cause.
package cov_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2,
    ST_HOLD = 2'd3
  } mon_state_e;

  localparam int CAUSE_CH0 = 0;

  // Watchdog cause sits just above the per-channel bits.
  function automatic int cause_wdog_bit(input int nch);
    return nch;
  endfunction

endpackage

// File: rtl/cov_stall_chan.sv
// One coverage channel: change tracking, saturating stall counter and
// coverage-scaled threshold compare.
module cov_stall_chan
  import cov_mon_pkg::*;
#(
  parameter int COV_W       = 30,
  parameter int CNT_W       = 32,
  parameter int BASE_WAIT   = 1000,
  parameter int SCALE_SHIFT = 19
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [COV_W-1:0] cov_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic             flag_o
`ifdef COV_STALL_MONITOR_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  localparam int PW = COV_W + 33;

  logic [COV_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr;
  logic [PW-1:0]    prod;
  logic             chg;

  assign chg  = (cov_i != prev_q);

  // Product is wide enough that any bit above CNT_W means overflow.
  assign prod = PW'(BASE_WAIT)
              * (PW'(cov_i >> SCALE_SHIFT) + PW'(1));
  assign thr  = (|prod[PW-1:CNT_W]) ? '1 : prod[CNT_W-1:0];

  assign flag_o = (cnt_q >= thr);

`ifdef COV_STALL_MONITOR_STATS_EN
  assign cnt_o = cnt_q;
`endif

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (chg) prev_d = cov_i;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (chg)             cnt_d = '0;
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cov_stall_monitor.sv
// Coverage stall / tohost watchdog interrupt monitor.
// Optional statistics outputs: define COV_STALL_MONITOR_STATS_EN.
module cov_stall_monitor
  import cov_mon_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int COV_W       = 30,
  parameter int CNT_W       = 32,
  parameter int BASE_WAIT   = 1000,
  parameter int SCALE_SHIFT = 19,
  parameter int WDOG_LIMIT  = 50000,
  parameter int HOLDOFF     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NCH*COV_W-1:0] cov,
  input  logic [63:0]          tohost,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic [NCH:0]         irq_cause
`ifdef COV_STALL_MONITOR_STATS_EN
  ,
  output logic [15:0]          fire_count,
  output logic [CNT_W-1:0]     max_stall
`endif
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int WDOG_BIT = cause_wdog_bit(NCH);

  mon_state_e state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [NCH:0]     cause_q, cause_d;
  logic [NCH-1:0]   flags;
  logic             pass, wdog_flag, any_flag;
  logic             clr, inc;
  logic             tohost_unused;

  assign pass          = tohost[0];
  assign tohost_unused = ^tohost[63:1];
  assign wdog_flag     = (wdog_q >= CNT_W'(WDOG_LIMIT));
  assign any_flag      = (|flags) | wdog_flag;

`ifdef COV_STALL_MONITOR_STATS_EN
  logic [NCH*CNT_W-1:0] cnts;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cov_stall_chan #(
      .COV_W      (COV_W),
      .CNT_W      (CNT_W),
      .BASE_WAIT  (BASE_WAIT),
      .SCALE_SHIFT(SCALE_SHIFT)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .cov_i (cov[i*COV_W +: COV_W]),
      .clr_i (clr),
      .inc_i (inc),
      .flag_o(flags[i])
`ifdef COV_STALL_MONITOR_STATS_EN
      ,
      .cnt_o (cnts[i*CNT_W +: CNT_W])
`endif
    );
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    clr     = 1'b0;
    inc     = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
        ST_RUN: begin
          // A tohost pass wins over any flag raised in the same cycle.
          if (pass) begin
            clr = 1'b1;
          end else begin
            inc = 1'b1;
            if (any_flag) begin
              state_d = ST_FIRE;
              cause_d = '0;
              cause_d[CAUSE_CH0 +: NCH] = flags;
              cause_d[WDOG_BIT] = wdog_flag;
            end
          end
        end
        ST_FIRE: begin
          if (irq_ack) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            clr     = 1'b1;
          end
        end
        ST_HOLD: begin
          clr = 1'b1;
          if (hold_q == HW'(HOLDOFF - 1)) state_d = ST_RUN;
          else hold_d = hold_q + HW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    if (clr)                      wdog_d = '0;
    else if (inc && wdog_q != '1) wdog_d = wdog_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      hold_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
    end
  end

  assign irq       = (state_q == ST_FIRE);
  assign irq_cause = cause_q;

`ifdef COV_STALL_MONITOR_STATS_EN
  logic [15:0]      fire_q;
  logic [CNT_W-1:0] max_q, cur_max;

  always_comb begin
    cur_max = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnts[i*CNT_W +: CNT_W] > cur_max) cur_max = cnts[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fire_q <= '0;
      max_q  <= '0;
    end else begin
      if (state_q == ST_RUN && state_d == ST_FIRE && fire_q != '1)
        fire_q <= fire_q + 16'd1;
      if (cur_max > max_q) max_q <= cur_max;
    end
  end

  assign fire_count = fire_q;
  assign max_stall  = max_q;
`endif

endmodule
